// File: rtl/memory_stage_pkg.sv
// Shared encodings for the MEM/WB slice: writeback select, load/store size codes, W-register payload.
package riscv_pkg;

    localparam int unsigned DATA_WIDTH             = 32;
    localparam int unsigned REG_FILE_ADDRESS_WIDTH = 5;
    localparam int unsigned DMEM_ADDR_WIDTH        = 12;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                              reg_write;
        logic [1:0]                        result_src;
        logic [REG_FILE_ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]             alu_result;
        logic [DATA_WIDTH-1:0]             pc_plus4;
        logic [2:0]                        funct3;
        logic [1:0]                        offset;
    } w_reg_t;

endpackage

// File: rtl/memory_stage_if.sv
// M-stage inputs and W-stage outputs of the memory stage; MisalignM exists only with DMEM_MISALIGN_TRAP_EN.
interface memory_stage_if;
    import riscv_pkg::*;

    logic                              RegWriteM;
    logic [1:0]                        ResultSrcM;
    logic                              MemWriteM;
    logic [2:0]                        Funct3M;
    logic [DATA_WIDTH-1:0]             ALUResultM;
    logic [DATA_WIDTH-1:0]             WriteDataM;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM;
    logic [DATA_WIDTH-1:0]             PCPlus4M;

    logic                              RegWriteW;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0]             ALUResultW;
    logic [DATA_WIDTH-1:0]             PCPlus4W;
    logic [DATA_WIDTH-1:0]             ReadDataW;
    logic [DATA_WIDTH-1:0]             ResultW;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic                              MisalignM;
`endif

    modport slave (
`ifdef DMEM_MISALIGN_TRAP_EN
        output MisalignM,
`endif
        input  RegWriteM, ResultSrcM, MemWriteM, Funct3M, ALUResultM, WriteDataM, RdM, PCPlus4M,
        output RegWriteW, RdW, ALUResultW, PCPlus4W, ReadDataW, ResultW
    );

    modport master (
`ifdef DMEM_MISALIGN_TRAP_EN
        input  MisalignM,
`endif
        output RegWriteM, ResultSrcM, MemWriteM, Funct3M, ALUResultM, WriteDataM, RdM, PCPlus4M,
        input  RegWriteW, RdW, ALUResultW, PCPlus4W, ReadDataW, ResultW
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Word-wide data memory with four byte-lane write enables and a registered (read-first) read port.
module data_mem #(
    parameter int unsigned WORD_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_AW-1:0] addr,
    input  logic [3:0]         be,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    localparam int unsigned DEPTH = 1 << WORD_AW;

    logic [31:0] mem [DEPTH];

    // Array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage plus MEM/WB register: store lane steering, data memory, load extension and ResultW mux.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DMEM_AW = DMEM_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    memory_stage_if.slave       bus
);

    localparam int unsigned WORD_AW = DMEM_AW - 2;

    logic [1:0]         offset;
    logic [WORD_AW-1:0] word_addr;
    logic [3:0]         lane_be;
    logic [31:0]        lane_data;
    logic [3:0]         mem_be;
    logic               misalign;
    logic [31:0]        raw_word;
    w_reg_t             w_d;
    w_reg_t             w_q;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        read_data;
    logic               unused_addr_bits;

    assign offset           = bus.ALUResultM[1:0];
    assign word_addr        = bus.ALUResultM[DMEM_AW-1:2];
    assign unused_addr_bits = ^bus.ALUResultM[DATA_WIDTH-1:DMEM_AW];

    // Byte enables and replicated store data by access size.
    always_comb begin
        lane_be   = 4'b0000;
        lane_data = bus.WriteDataM;
        case (bus.Funct3M[1:0])
            2'b00: begin
                lane_be   = 4'(4'b0001 << offset);
                lane_data = {4{bus.WriteDataM[7:0]}};
            end
            2'b01: begin
                lane_be   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.WriteDataM[15:0]}};
            end
            2'b10:   lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (bus.MemWriteM || (bus.ResultSrcM == RES_MEM)) begin
            misalign = ((bus.Funct3M[1:0] == 2'b01) && offset[0]) ||
                       ((bus.Funct3M[1:0] == 2'b10) && (offset != 2'b00));
        end
    end
    assign bus.MisalignM = misalign;
`else
    assign misalign = 1'b0;
`endif

    assign mem_be = (bus.MemWriteM && !rst && !misalign) ? lane_be : 4'b0000;

    data_mem #(.WORD_AW(WORD_AW)) u_data_mem (
        .clk   (clk),
        .rst   (rst),
        .addr  (word_addr),
        .be    (mem_be),
        .wdata (lane_data),
        .rdata (raw_word)
    );

    // Misaligned loads must not reach the register file.
    always_comb begin
        w_d.reg_write  = bus.RegWriteM && !(misalign && (bus.ResultSrcM == RES_MEM));
        w_d.result_src = bus.ResultSrcM;
        w_d.rd         = bus.RdM;
        w_d.alu_result = bus.ALUResultM;
        w_d.pc_plus4   = bus.PCPlus4M;
        w_d.funct3     = bus.Funct3M;
        w_d.offset     = offset;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    assign ld_byte = raw_word[{w_q.offset, 3'b000} +: 8];
    assign ld_half = w_q.offset[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        read_data = raw_word;
        case (w_q.funct3)
            F3_B:    read_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    read_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   read_data = {24'h0, ld_byte};
            F3_HU:   read_data = {16'h0, ld_half};
            default: read_data = raw_word;
        endcase
    end

    always_comb begin
        bus.ResultW = 32'h0;
        case (w_q.result_src)
            RES_ALU: bus.ResultW = w_q.alu_result;
            RES_MEM: bus.ResultW = read_data;
            RES_PC4: bus.ResultW = w_q.pc_plus4;
            default: bus.ResultW = 32'h0;
        endcase
    end

    assign bus.ReadDataW  = read_data;
    assign bus.RegWriteW  = w_q.reg_write;
    assign bus.RdW        = w_q.rd;
    assign bus.ALUResultW = w_q.alu_result;
    assign bus.PCPlus4W   = w_q.pc_plus4;

endmodule

// File: tb/tb_memory_stage.sv
// Directed, table-driven bench for memory_stage; extra trap checks when DMEM_MISALIGN_TRAP_EN is defined.
module tb_memory_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    memory_stage_if bus ();

    memory_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        rw;
        logic [1:0]  src;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        exp_rw;
        logic        chk_read;
        logic [31:0] exp_read;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] src, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4);
        bus.RegWriteM  = rw;
        bus.ResultSrcM = src;
        bus.MemWriteM  = mw;
        bus.Funct3M    = f3;
        bus.ALUResultM = alu;
        bus.WriteDataM = wd;
        bus.RdM        = rd;
        bus.PCPlus4M   = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic rw, input logic [1:0] src, input logic mw,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4, input logic exp_rw,
                       input logic chk_read, input logic [31:0] exp_read, input logic [31:0] exp_result);
        vec_t v;
        v = '{name, rw, src, mw, f3, alu, wd, rd, pc4, exp_rw, chk_read, exp_read, exp_result};
        vecs.push_back(v);
    endtask

    task automatic check_w_zero(input string tag);
        check32({tag, "_regwrite"}, 32'(bus.RegWriteW), 32'h0);
        check32({tag, "_rd"}, 32'(bus.RdW), 32'h0);
        check32({tag, "_alu"}, bus.ALUResultW, 32'h0);
        check32({tag, "_pc4"}, bus.PCPlus4W, 32'h0);
        check32({tag, "_readdata"}, bus.ReadDataW, 32'h0);
        check32({tag, "_result"}, bus.ResultW, 32'h0);
    endtask

    initial begin
        // name, rw, src, mw, f3, alu, wd, rd, pc4, exp_rw, chk_read, exp_read, exp_result
        add("sw_deadbeef", 0, 2'b00, 1, 3'b010, 32'h20,   32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h20);
        add("lb_21",       1, 2'b01, 0, 3'b000, 32'h21,   0, 3, 0, 1, 1, 32'hFFFFFFBE, 32'hFFFFFFBE);
        add("lbu_23",      1, 2'b01, 0, 3'b100, 32'h23,   0, 4, 0, 1, 1, 32'h000000DE, 32'h000000DE);
        add("lhu_22",      1, 2'b01, 0, 3'b101, 32'h22,   0, 6, 0, 1, 1, 32'h0000DEAD, 32'h0000DEAD);
        add("lw_alias",    1, 2'b01, 0, 3'b010, 32'h1020, 0, 8, 0, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        add("sw_clr30",    0, 2'b00, 1, 3'b010, 32'h30,   32'h0, 0, 0, 0, 0, 0, 32'h30);
        add("sb_31",       0, 2'b00, 1, 3'b000, 32'h31,   32'hAAAAAA7F, 0, 0, 0, 0, 0, 32'h31);
        add("lw_30_a",     1, 2'b01, 0, 3'b010, 32'h30,   0, 1, 0, 1, 1, 32'h00007F00, 32'h00007F00);
        add("sh_32",       0, 2'b00, 1, 3'b001, 32'h32,   32'h55558001, 0, 0, 0, 0, 0, 32'h32);
        add("lw_30_b",     1, 2'b01, 0, 3'b010, 32'h30,   0, 2, 0, 1, 1, 32'h80017F00, 32'h80017F00);
        add("lh_32",       1, 2'b01, 0, 3'b001, 32'h32,   0, 2, 0, 1, 1, 32'hFFFF8001, 32'hFFFF8001);
        add("lh_30",       1, 2'b01, 0, 3'b001, 32'h30,   0, 2, 0, 1, 1, 32'h00007F00, 32'h00007F00);
        add("lb_33",       1, 2'b01, 0, 3'b000, 32'h33,   0, 2, 0, 1, 1, 32'hFFFFFF80, 32'hFFFFFF80);
        add("pc4_sel",     1, 2'b10, 0, 3'b010, 32'h33,   0, 5, 32'h104, 1, 0, 0, 32'h104);
        add("src_11",      1, 2'b11, 0, 3'b010, 32'h33,   0, 7, 32'h200, 1, 0, 0, 32'h0);
        add("alu_sel",     1, 2'b00, 0, 3'b010, 32'h12345678, 0, 9, 0, 1, 0, 0, 32'h12345678);
        add("sw_and_rw",   1, 2'b00, 1, 3'b010, 32'h40,   32'hCAFEF00D, 10, 0, 1, 0, 0, 32'h40);
        add("lw_40",       1, 2'b01, 0, 3'b010, 32'h40,   0, 11, 0, 1, 1, 32'hCAFEF00D, 32'hCAFEF00D);
        add("f3_011_raw",  1, 2'b01, 0, 3'b011, 32'h40,   0, 12, 0, 1, 1, 32'hCAFEF00D, 32'hCAFEF00D);
        add("lhu_42",      1, 2'b01, 0, 3'b101, 32'h42,   0, 13, 0, 1, 1, 32'h0000CAFE, 32'h0000CAFE);
        add("lbu_40",      1, 2'b01, 0, 3'b100, 32'h40,   0, 14, 0, 1, 1, 32'h0000000D, 32'h0000000D);

        rst = 1'b1;
        drive(1, 2'b10, 0, 3'b010, 32'h44, 32'h0, 5'd3, 32'h99);
        tick();
        check_w_zero("reset0");

        // Seed a word, then hold reset two cycles with a store to it and confirm it survived.
        rst = 1'b0;
        drive(0, 2'b00, 1, 3'b010, 32'h10, 32'h12345678, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 2'b01, 1, 3'b010, 32'h10, 32'hFFFFFFFF, 5'd9, 32'h50);
        tick();
        check_w_zero("reset1");
        tick();
        check_w_zero("reset2");
        rst = 1'b0;
        drive(1, 2'b01, 0, 3'b010, 32'h10, 0, 5'd2, 0);
        tick();
        check32("reset_store_suppressed", bus.ReadDataW, 32'h12345678);
        check32("lw_10_rd", 32'(bus.RdW), 32'd2);

        foreach (vecs[i]) begin
            drive(vecs[i].rw, vecs[i].src, vecs[i].mw, vecs[i].f3, vecs[i].alu,
                  vecs[i].wd, vecs[i].rd, vecs[i].pc4);
            tick();
            check32({vecs[i].name, "_regwrite"}, 32'(bus.RegWriteW), 32'(vecs[i].exp_rw));
            check32({vecs[i].name, "_rd"}, 32'(bus.RdW), 32'(vecs[i].rd));
            check32({vecs[i].name, "_alu"}, bus.ALUResultW, vecs[i].alu);
            check32({vecs[i].name, "_pc4"}, bus.PCPlus4W, vecs[i].pc4);
            check32({vecs[i].name, "_result"}, bus.ResultW, vecs[i].exp_result);
            if (vecs[i].chk_read) begin
                check32({vecs[i].name, "_readdata"}, bus.ReadDataW, vecs[i].exp_read);
            end
        end

`ifdef DMEM_MISALIGN_TRAP_EN
        drive(0, 2'b00, 1, 3'b010, 32'h41, 32'h11111111, 0, 0);
        #1;
        check32("misalign_sw_flag", 32'(bus.MisalignM), 32'h1);
        tick();
        drive(1, 2'b01, 0, 3'b010, 32'h40, 0, 5'd15, 0);
        #1;
        check32("aligned_lw_flag", 32'(bus.MisalignM), 32'h0);
        tick();
        check32("misalign_sw_no_write", bus.ReadDataW, 32'hCAFEF00D);
        drive(1, 2'b01, 0, 3'b001, 32'h43, 0, 5'd16, 0);
        #1;
        check32("misalign_lh_flag", 32'(bus.MisalignM), 32'h1);
        tick();
        check32("misalign_lh_regwrite", 32'(bus.RegWriteW), 32'h0);
        check32("misalign_lh_rd", 32'(bus.RdW), 32'd16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
